gpio_cfg_loader: RTL and testbench

Sequencer that serially programs the per-pad configuration of the user I/O pad ring (drive mode, input disable, trip/slew select, hold override, analog controls, output enable). It reads one configuration word per pad from the housekeeping register file and shifts the words into two daisy-chained pad control chains in parallel: area 1 (pads 0..AREA1PADS-1) and area 2 (pads AREA1PADS..NPADS-1). A single load strobe then transfers all shifted words into the pad control registers simultaneously. It sits between housekeeping and the pad control blocks that drive the pad array.

---
 rtl/gpio_cfg_pkg.sv | 45 ++++
 rtl/gpio_cfg_if.sv | 45 ++++
 rtl/gpio_cfg_clkgen.sv | 36 +++
 rtl/gpio_cfg_loader.sv | 203 ++++++++++++++++++++
 tb/tb_gpio_cfg_loader.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_cfg_pkg.sv
// gpio_cfg_pkg
// Shared types and elaboration-time helpers for the pad-ring configuration
// loader: FSM state encoding, default configuration word width and the
// functions that derive the number of word slots and per-chain padding.
// Optional feature macro: GPIO_CFG_CHAIN_RESET_EN (adds the CRST state).

package gpio_cfg_pkg;

    localparam int CFG_BITS_DEF = 13;

    typedef enum logic [2:0] {
        IDLE,
`ifdef GPIO_CFG_CHAIN_RESET_EN
        CRST,
`endif
        LOAD,
        SHIFT_LO,
        SHIFT_HI,
        LATCH,
        DONE
    } state_t;

    // Number of word slots shifted into both chains: the longer chain sets it.
    function automatic int slot_count(input int npads, input int area1);
        int area2;
        area2 = npads - area1;
        return (area1 > area2) ? area1 : area2;
    endfunction

    // Leading all-zero words pushed into chain 1 so its real words end up
    // aligned once the surplus bits have fallen off the far end.
    function automatic int pad_slots_1(input int npads, input int area1);
        return slot_count(npads, area1) - area1;
    endfunction

    function automatic int pad_slots_2(input int npads, input int area1);
        return slot_count(npads, area1) - (npads - area1);
    endfunction

    // Counter width that stays legal when the count is 1.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/gpio_cfg_if.sv
// gpio_cfg_if
// Bundles the loader's handshake, register-file read port and serial chain
// outputs.
//   start/busy/done           : load request and status
//   cfg_addr_x / cfg_data_x   : per-chain register-file read (data is combinational)
//   serial_clock/data_x/load  : pad control chain shift clock, data, transfer strobe
//   serial_resetn             : pad control chain reset, active-low
// modport master: the loader; modport slave: housekeeping / pad side.

interface gpio_cfg_if
    import gpio_cfg_pkg::*;
#(
    parameter int NPADS    = 38,
    parameter int CFG_BITS = CFG_BITS_DEF
);
    localparam int AW = $clog2(NPADS);

    logic                start;
    logic                busy;
    logic                done;
    logic [AW-1:0]       cfg_addr_1;
    logic [AW-1:0]       cfg_addr_2;
    logic [CFG_BITS-1:0] cfg_data_1;
    logic [CFG_BITS-1:0] cfg_data_2;
    logic                serial_clock;
    logic                serial_data_1;
    logic                serial_data_2;
    logic                serial_load;
    logic                serial_resetn;

    modport master (
        input  start, cfg_data_1, cfg_data_2,
        output busy, done, cfg_addr_1, cfg_addr_2,
               serial_clock, serial_data_1, serial_data_2,
               serial_load, serial_resetn
    );

    modport slave (
        output start, cfg_data_1, cfg_data_2,
        input  busy, done, cfg_addr_1, cfg_addr_2,
               serial_clock, serial_data_1, serial_data_2,
               serial_load, serial_resetn
    );

endinterface

// File: rtl/gpio_cfg_clkgen.sv
// gpio_cfg_clkgen
// Half-period timer for the serial chain clock. Produces a phase-end tick
// on the last cycle of every CLK_DIV-cycle phase; restart holds the counter
// at zero so the next phase begins with a full CLK_DIV cycles.
//   clk, resetn : system clock, asynchronous active-low reset
//   restart     : hold/reset the phase counter
//   tick        : last cycle of the current phase

module gpio_cfg_clkgen
    import gpio_cfg_pkg::*;
#(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);
    localparam int            CW   = cnt_width(CLK_DIV);
    localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (restart || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/gpio_cfg_loader.sv
// gpio_cfg_loader
// Serially programs the user I/O pad ring. One configuration word per pad
// is read from the housekeeping register file and shifted MSB-first into
// two daisy-chained pad control chains in parallel (chain 1: pads
// 0..AREA1PADS-1, chain 2: the rest), then a single serial_load strobe
// transfers every shifted word into the pad registers at once.
// Ports:
//   clk, resetn : system clock, asynchronous active-low reset
//   bus         : gpio_cfg_if.master (start/busy/done, cfg_addr/cfg_data,
//                 serial_clock/data_1/data_2/load/resetn)
// Optional feature macro: GPIO_CFG_CHAIN_RESET_EN -- when defined, the
// chains are held in reset (serial_resetn=0) for CLK_DIV cycles before the
// first word; otherwise serial_resetn is tied high.

module gpio_cfg_loader
    import gpio_cfg_pkg::*;
#(
    parameter int NPADS     = 38,
    parameter int AREA1PADS = 19,
    parameter int CFG_BITS  = CFG_BITS_DEF,
    parameter int CLK_DIV   = 2
) (
    input  logic      clk,
    input  logic      resetn,
    gpio_cfg_if.master bus
);
    localparam int AW = $clog2(NPADS);
    localparam int W  = slot_count(NPADS, AREA1PADS);
    localparam int P1 = pad_slots_1(NPADS, AREA1PADS);
    localparam int P2 = pad_slots_2(NPADS, AREA1PADS);
    localparam int SW = cnt_width(W);
    localparam int BW = cnt_width(CFG_BITS);

    state_t              state;
    logic [SW-1:0]       slot;
    logic [BW-1:0]       bit_cnt;
    logic [CFG_BITS-1:0] sr1;
    logic [CFG_BITS-1:0] sr2;
    logic                pad1;
    logic                pad2;
    logic [AW-1:0]       addr1;
    logic [AW-1:0]       addr2;
    logic                busy_r;
    logic                done_r;
    logic                sclk_r;
    logic                sload_r;

    logic                tick;
    logic                restart;

    // Values for the slot about to be loaded: slot 0 when leaving IDLE/CRST,
    // the following slot when leaving the last bit of SHIFT_HI.
    logic [SW-1:0]       slot_tgt;
    logic                ld_pad1;
    logic                ld_pad2;
    logic [AW-1:0]       ld_addr1;
    logic [AW-1:0]       ld_addr2;

    always_comb begin
        slot_tgt = '0;
        if (state == SHIFT_HI) begin
            slot_tgt = slot + SW'(1);
        end
        // Padding slots keep the previous address; the word is zeroed at capture.
        ld_pad1  = int'(slot_tgt) < P1;
        ld_pad2  = int'(slot_tgt) < P2;
        ld_addr1 = ld_pad1 ? addr1 : AW'(AREA1PADS - 1 + P1 - int'(slot_tgt));
        ld_addr2 = ld_pad2 ? addr2 : AW'(AREA1PADS - P2 + int'(slot_tgt));
    end

    assign restart = (state == IDLE) || (state == LOAD) || (state == DONE);

    gpio_cfg_clkgen #(
        .CLK_DIV (CLK_DIV)
    ) u_clkgen (
        .clk     (clk),
        .resetn  (resetn),
        .restart (restart),
        .tick    (tick)
    );

`ifdef GPIO_CFG_CHAIN_RESET_EN
    logic srst_r;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state   <= IDLE;
            slot    <= '0;
            bit_cnt <= '0;
            sr1     <= '0;
            sr2     <= '0;
            pad1    <= 1'b0;
            pad2    <= 1'b0;
            addr1   <= '0;
            addr2   <= '0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            sclk_r  <= 1'b0;
            sload_r <= 1'b0;
`ifdef GPIO_CFG_CHAIN_RESET_EN
            srst_r  <= 1'b1;
`endif
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        busy_r <= 1'b1;
`ifdef GPIO_CFG_CHAIN_RESET_EN
                        srst_r <= 1'b0;
                        state  <= CRST;
`else
                        slot   <= slot_tgt;
                        pad1   <= ld_pad1;
                        pad2   <= ld_pad2;
                        addr1  <= ld_addr1;
                        addr2  <= ld_addr2;
                        state  <= LOAD;
`endif
                    end
                end
`ifdef GPIO_CFG_CHAIN_RESET_EN
                CRST: begin
                    if (tick) begin
                        srst_r <= 1'b1;
                        slot   <= slot_tgt;
                        pad1   <= ld_pad1;
                        pad2   <= ld_pad2;
                        addr1  <= ld_addr1;
                        addr2  <= ld_addr2;
                        state  <= LOAD;
                    end
                end
`endif
                LOAD: begin
                    sr1     <= pad1 ? '0 : bus.cfg_data_1;
                    sr2     <= pad2 ? '0 : bus.cfg_data_2;
                    bit_cnt <= '0;
                    state   <= SHIFT_LO;
                end
                SHIFT_LO: begin
                    if (tick) begin
                        sclk_r <= 1'b1;
                        state  <= SHIFT_HI;
                    end
                end
                SHIFT_HI: begin
                    if (tick) begin
                        sclk_r <= 1'b0;
                        sr1    <= {sr1[CFG_BITS-2:0], 1'b0};
                        sr2    <= {sr2[CFG_BITS-2:0], 1'b0};
                        if (bit_cnt == BW'(CFG_BITS - 1)) begin
                            if (slot == SW'(W - 1)) begin
                                sload_r <= 1'b1;
                                state   <= LATCH;
                            end else begin
                                slot  <= slot_tgt;
                                pad1  <= ld_pad1;
                                pad2  <= ld_pad2;
                                addr1 <= ld_addr1;
                                addr2 <= ld_addr2;
                                state <= LOAD;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                            state   <= SHIFT_LO;
                        end
                    end
                end
                LATCH: begin
                    if (tick) begin
                        sload_r <= 1'b0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy          = busy_r;
    assign bus.done          = done_r;
    assign bus.cfg_addr_1    = addr1;
    assign bus.cfg_addr_2    = addr2;
    assign bus.serial_clock  = sclk_r;
    assign bus.serial_data_1 = sr1[CFG_BITS-1];
    assign bus.serial_data_2 = sr2[CFG_BITS-1];
    assign bus.serial_load   = sload_r;
`ifdef GPIO_CFG_CHAIN_RESET_EN
    assign bus.serial_resetn = srst_r;
`else
    assign bus.serial_resetn = 1'b1;
`endif

endmodule

// File: tb/tb_gpio_cfg_loader.sv
// tb_gpio_cfg_loader
// Directed bench for gpio_cfg_loader. Two instances run side by side:
// dut_a with the default ring (38 pads, 19 per chain) and dut_b with 37
// pads split 18/19 so chain 1 receives one leading padding word.
// Honours GPIO_CFG_CHAIN_RESET_EN for the chain-reset phase.

module tb_gpio_cfg_loader;

    localparam int CD = 2;
    localparam int CB = 13;
`ifdef GPIO_CFG_CHAIN_RESET_EN
    localparam int CR = CD;
`else
    localparam int CR = 0;
`endif
    localparam int SLOT_LEN = 1 + 2 * CD * CB;
    localparam int WA       = 19;
    localparam int DONE_CYC = 1 + CR + WA * SLOT_LEN + CD;

    logic clk    = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    gpio_cfg_if #(.NPADS(38), .CFG_BITS(CB)) ifa ();
    gpio_cfg_if #(.NPADS(37), .CFG_BITS(CB)) ifb ();

    gpio_cfg_loader #(.NPADS(38), .AREA1PADS(19), .CFG_BITS(CB), .CLK_DIV(CD)) dut_a (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifa.master)
    );

    gpio_cfg_loader #(.NPADS(37), .AREA1PADS(18), .CFG_BITS(CB), .CLK_DIV(CD)) dut_b (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifb.master)
    );

    // Register-file contents: fixed words on pads 18/19, a scrambled pattern elsewhere.
    function automatic logic [12:0] pad_word(input int i);
        int w;
        if (i == 18) return 13'h1A5B;
        if (i == 19) return 13'h0403;
        w = (i * 37 + 5) ^ (i << 7);
        return w[12:0];
    endfunction

    assign ifa.cfg_data_1 = pad_word(int'(ifa.cfg_addr_1));
    assign ifa.cfg_data_2 = pad_word(int'(ifa.cfg_addr_2));
    assign ifb.cfg_data_1 = pad_word(int'(ifb.cfg_addr_1));
    assign ifb.cfg_data_2 = pad_word(int'(ifb.cfg_addr_2));

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-run observations
    int   a_done_cnt, a_done_cyc, a_busy_cnt;
    int   a_sload_cnt, a_sload_first, a_sload_last;
    int   a_srst_cnt, a_srst_first, a_srst_last;
    int   b_done_cyc;
    logic [5:0] a_addr1 [WA];
    logic [5:0] a_addr2 [WA];
    logic a_bits1 [$];
    logic a_bits2 [$];
    logic b_bits1 [$];
    logic b_bits2 [$];
    logic post_busy, post_sclk, post_sdata;

    // Reassemble slot k (MSB first) from a captured bit stream.
    function automatic logic [12:0] word_at(input logic q[$], input int k);
        logic [12:0] w;
        for (int b = 0; b < CB; b++) begin
            int idx;
            idx = k * CB + b;
            w[CB-1-b] = (idx < q.size()) ? q[idx] : 1'bx;
        end
        return w;
    endfunction

    // Pulse start, then observe ncyc cycles (cycle 1 = first cycle after start
    // is sampled). Extra start pulses at cycles ra/rb; resetn low at rst_at.
    task automatic run_load(input int ncyc, input int ra, input int rb, input int rst_at);
        logic a_prev, b_prev;
        int   k;
        a_done_cnt = 0; a_done_cyc = -1; a_busy_cnt = 0;
        a_sload_cnt = 0; a_sload_first = -1; a_sload_last = -1;
        a_srst_cnt = 0; a_srst_first = -1; a_srst_last = -1;
        b_done_cyc = -1;
        for (int i = 0; i < WA; i++) begin
            a_addr1[i] = 6'h3F;
            a_addr2[i] = 6'h3F;
        end
        a_bits1.delete(); a_bits2.delete(); b_bits1.delete(); b_bits2.delete();
        post_busy = 1'bx; post_sclk = 1'bx; post_sdata = 1'bx;
        a_prev = 1'b0; b_prev = 1'b0;

        @(negedge clk);
        ifa.start = 1'b1;
        ifb.start = 1'b1;
        @(posedge clk);
        #1;
        ifa.start = 1'b0;
        ifb.start = 1'b0;

        for (int c = 1; c <= ncyc; c++) begin
            if (ifa.done) begin a_done_cnt++; a_done_cyc = c; end
            if (ifa.busy) a_busy_cnt++;
            if (ifa.serial_load) begin
                a_sload_cnt++;
                if (a_sload_first < 0) a_sload_first = c;
                a_sload_last = c;
            end
            if (!ifa.serial_resetn) begin
                a_srst_cnt++;
                if (a_srst_first < 0) a_srst_first = c;
                a_srst_last = c;
            end
            if (ifa.serial_clock && !a_prev) begin
                a_bits1.push_back(ifa.serial_data_1);
                a_bits2.push_back(ifa.serial_data_2);
            end
            a_prev = ifa.serial_clock;
            if (c >= 1 + CR && (c - 1 - CR) % SLOT_LEN == 0 && (c - 1 - CR) / SLOT_LEN < WA) begin
                k = (c - 1 - CR) / SLOT_LEN;
                a_addr1[k] = ifa.cfg_addr_1;
                a_addr2[k] = ifa.cfg_addr_2;
            end
            if (ifb.done) b_done_cyc = c;
            if (ifb.serial_clock && !b_prev) begin
                b_bits1.push_back(ifb.serial_data_1);
                b_bits2.push_back(ifb.serial_data_2);
            end
            b_prev = ifb.serial_clock;
            if (c == rst_at + 1) begin
                post_busy  = ifa.busy;
                post_sclk  = ifa.serial_clock;
                post_sdata = ifa.serial_data_1;
            end

            ifa.start = (c == ra) || (c == rb);
            ifb.start = (c == ra) || (c == rb);
            if (c == rst_at)     resetn = 1'b0;
            if (c == rst_at + 2) resetn = 1'b1;
            @(posedge clk);
            #1;
        end
        ifa.start = 1'b0;
        ifb.start = 1'b0;
    endtask

    initial begin
        int errs;
        ifa.start = 1'b0;
        ifb.start = 1'b0;
        resetn    = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        check("rst_busy",   32'(ifa.busy),          32'd0);
        check("rst_done",   32'(ifa.done),          32'd0);
        check("rst_sclk",   32'(ifa.serial_clock),  32'd0);
        check("rst_sdata1", 32'(ifa.serial_data_1), 32'd0);
        check("rst_sdata2", 32'(ifa.serial_data_2), 32'd0);
        check("rst_sload",  32'(ifa.serial_load),   32'd0);
        check("rst_srstn",  32'(ifa.serial_resetn), 32'd1);
        check("rst_addr1",  32'(ifa.cfg_addr_1),    32'd0);
        check("rst_addr2",  32'(ifa.cfg_addr_2),    32'd0);

        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Full load with ignored start pulses at cycles 5 and 500
        run_load(DONE_CYC + 5, 5, 500, -10);
        check("a_done_cyc",    a_done_cyc,    DONE_CYC);
        check("a_done_cnt",    a_done_cnt,    1);
        check("a_busy_cnt",    a_busy_cnt,    DONE_CYC - 1);
        check("a_sload_first", a_sload_first, DONE_CYC - CD);
        check("a_sload_last",  a_sload_last,  DONE_CYC - 1);
        check("a_sload_cnt",   a_sload_cnt,   CD);
        check("a_srst_cnt",    a_srst_cnt,    CR);
`ifdef GPIO_CFG_CHAIN_RESET_EN
        check("a_srst_first",  a_srst_first,  1);
        check("a_srst_last",   a_srst_last,   CR);
`endif
        for (int k = 0; k < WA; k++) begin
            check($sformatf("a_addr1[%0d]", k), 32'(a_addr1[k]), 18 - k);
            check($sformatf("a_addr2[%0d]", k), 32'(a_addr2[k]), 19 + k);
        end
        check("a_nbits",       a_bits1.size(), WA * CB);
        check("a_word1_pad18", 32'(word_at(a_bits1, 0)), 32'h1A5B);
        check("a_word2_pad19", 32'(word_at(a_bits2, 0)), 32'h0403);
        errs = 0;
        for (int k = 0; k < WA; k++) if (word_at(a_bits1, k) !== pad_word(18 - k)) errs++;
        check("a_stream1_errs", errs, 0);
        errs = 0;
        for (int k = 0; k < WA; k++) if (word_at(a_bits2, k) !== pad_word(19 + k)) errs++;
        check("a_stream2_errs", errs, 0);

        // Uneven split: chain 1 starts with one zero padding word
        check("b_done_cyc",     b_done_cyc, DONE_CYC);
        check("b_word1_slot0",  32'(word_at(b_bits1, 0)), 32'h0);
        check("b_word1_slot1",  32'(word_at(b_bits1, 1)), 32'(pad_word(17)));
        check("b_word2_slot0",  32'(word_at(b_bits2, 0)), 32'(pad_word(18)));
        errs = 0;
        for (int k = 1; k < WA; k++) if (word_at(b_bits1, k) !== pad_word(18 - k)) errs++;
        check("b_stream1_errs", errs, 0);
        errs = 0;
        for (int k = 0; k < WA; k++) if (word_at(b_bits2, k) !== pad_word(18 + k)) errs++;
        check("b_stream2_errs", errs, 0);

        // Reset in the middle of a load
        run_load(400, 0, 0, 300);
        check("rst_mid_busy",  32'(post_busy),  32'd0);
        check("rst_mid_sclk",  32'(post_sclk),  32'd0);
        check("rst_mid_sdata", 32'(post_sdata), 32'd0);
        check("rst_mid_sload", a_sload_cnt, 0);
        check("rst_mid_done",  a_done_cnt,  0);

        // Fresh load after the abort
        run_load(DONE_CYC + 5, 0, 0, -10);
        check("again_done_cyc", a_done_cyc, DONE_CYC);
        check("again_done_cnt", a_done_cnt, 1);
        check("again_word1",    32'(word_at(a_bits1, 0)), 32'h1A5B);
        check("again_b_done",   b_done_cyc, DONE_CYC);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
